// File: rtl/rat_io_pkg.sv
// Shared MCU I/O port map and colour helpers for the RGB LED PWM driver.
// Colour codes follow the port ID order so decode is a simple subtraction.
package rat_io_pkg;

    localparam logic [7:0] PID_RED    = 8'h95;
    localparam logic [7:0] PID_BLU    = 8'h96;
    localparam logic [7:0] PID_LIBLU  = 8'h97;
    localparam logic [7:0] PID_LIGRE  = 8'h98;
    localparam logic [7:0] PID_LIRED  = 8'h99;
    localparam logic [7:0] PID_YEL    = 8'h9A;
    localparam logic [7:0] PID_PUR    = 8'h9B;
    localparam logic [7:0] PID_GREEN  = 8'h9C;
    localparam logic [7:0] PID_WHITE  = 8'h9D;
    localparam logic [7:0] PID_BLACK  = 8'h9E;
    localparam logic [7:0] PID_BRIGHT = 8'h9F;
    localparam logic [7:0] PID_BLINK  = 8'hA0;

    typedef enum logic [3:0] {
        COL_RED   = 4'd0,
        COL_BLU   = 4'd1,
        COL_LIBLU = 4'd2,
        COL_LIGRE = 4'd3,
        COL_LIRED = 4'd4,
        COL_YEL   = 4'd5,
        COL_PUR   = 4'd6,
        COL_GREEN = 4'd7,
        COL_WHITE = 4'd8,
        COL_BLACK = 4'd9
    } colour_t;

    function automatic logic [23:0] colour_rgb(input colour_t c);
        logic [23:0] rgb;
        case (c)
            COL_RED:   rgb = 24'hFF0000;
            COL_BLU:   rgb = 24'h0000FF;
            COL_LIBLU: rgb = 24'h4080FF;
            COL_LIGRE: rgb = 24'h80FF80;
            COL_LIRED: rgb = 24'hFF8080;
            COL_YEL:   rgb = 24'hFFFF00;
            COL_PUR:   rgb = 24'h800080;
            COL_GREEN: rgb = 24'h00FF00;
            COL_WHITE: rgb = 24'hFFFFFF;
            COL_BLACK: rgb = 24'h000000;
            default:   rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // (bright+1) scaling keeps full brightness lossless: base*256>>8 == base.
    function automatic logic [7:0] scale_duty(input logic [7:0] base, input logic [7:0] bright);
        logic [15:0] prod;
        prod = 16'(base) * (16'(bright) + 16'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler producing a tick every PRESCALE+1 clocks and a
// free-running CNT_W-bit period counter advancing on each tick.
module pwm_timebase #(
    parameter int PRESCALE = 49,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o,
    output logic             wrap_o
);

    localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_s;

    // Prescaler and counter next-state
    always_comb begin
        tick_s  = (presc_q == PS_W'(PRESCALE));
        presc_d = presc_q + {{(PS_W-1){1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        if (tick_s) begin
            presc_d = {PS_W{1'b0}};
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d   = cnt_q;
        end
    end

    // Timebase state registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            presc_q <= {PS_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = tick_s;
    assign wrap_o = tick_s && (&cnt_q);

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED PWM driver on the MCU I/O bus: decodes colour, brightness and blink
// writes and drives glitch-free PWM, switching colour only at period boundaries.
module rgb_led_pwm
    import rat_io_pkg::*;
#(
    parameter int PRESCALE = 49,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic       RED,
    output logic       GREEN,
    output logic       BLUE,
    output logic       FRAME
);

    localparam int CW = (CNT_W > 8) ? CNT_W : 8;

    logic [CNT_W-1:0] cnt_s;
    logic             tick_s, wrap_s, period_end_s;

    colour_t    pend_col_q, pend_col_d, cur_col_q, cur_col_d;
    logic [7:0] pend_bri_q, pend_bri_d, cur_bri_q, cur_bri_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] blink_q, blink_d, blink_cnt_q, blink_cnt_d;
    logic       en_q, en_d;
    logic       red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic       wr_col_s, wr_bri_s, wr_blk_s;
    logic [23:0] rgb_s;
    logic [CW-1:0] cnt_x_s, duty_r_s, duty_g_s, duty_b_s;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timebase (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .cnt_o   (cnt_s),
        .tick_o  (tick_s),
        .wrap_o  (wrap_s)
    );

    assign period_end_s = tick_s && wrap_s;

    // Bus decode, pending/current colour hand-over and blink sequencing
    always_comb begin
        wr_col_s    = IO_STRB && (PORT_ID >= PID_RED) && (PORT_ID <= PID_BLACK);
        wr_bri_s    = IO_STRB && (PORT_ID == PID_BRIGHT);
        wr_blk_s    = IO_STRB && (PORT_ID == PID_BLINK);
        pend_col_d  = pend_col_q;
        pend_bri_d  = pend_bri_q;
        pend_vld_d  = pend_vld_q;
        cur_col_d   = cur_col_q;
        cur_bri_d   = cur_bri_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        en_d        = en_q;

        if (period_end_s && pend_vld_q) begin
            cur_col_d  = pend_col_q;
            cur_bri_d  = pend_bri_q;
            pend_vld_d = 1'b0;
        end else begin
            cur_col_d  = cur_col_q;
        end

        // A write on the wrap cycle lands in pend and re-arms pend_vld for the next wrap.
        if (wr_col_s) begin
            pend_col_d = colour_t'(4'(PORT_ID - PID_RED));
        end else begin
            pend_col_d = pend_col_d;
        end
        if (wr_bri_s) begin
            pend_bri_d = OUT_PORT;
        end else begin
            pend_bri_d = pend_bri_d;
        end
        if (wr_col_s || wr_bri_s || wr_blk_s) begin
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_d;
        end

        if (wr_blk_s) begin
            blink_d     = OUT_PORT;
            blink_cnt_d = 8'd0;
            en_d        = 1'b1;
        end else if (blink_q == 8'd0) begin
            blink_cnt_d = 8'd0;
            en_d        = 1'b1;
        end else if (period_end_s) begin
            if (blink_cnt_q == blink_q) begin
                blink_cnt_d = 8'd0;
                en_d        = ~en_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Duty per channel from the applied colour/brightness and PWM compare
    always_comb begin
        rgb_s    = colour_rgb(cur_col_q);
        cnt_x_s  = CW'(cnt_s);
        duty_r_s = CW'(scale_duty(rgb_s[23:16], cur_bri_q));
        duty_g_s = CW'(scale_duty(rgb_s[15:8],  cur_bri_q));
        duty_b_s = CW'(scale_duty(rgb_s[7:0],   cur_bri_q));
        red_d    = en_q && (cnt_x_s < duty_r_s);
        green_d  = en_q && (cnt_x_s < duty_g_s);
        blue_d   = en_q && (cnt_x_s < duty_b_s);
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pend_col_q  <= COL_BLACK;
            pend_bri_q  <= 8'hFF;
            pend_vld_q  <= 1'b0;
            cur_col_q   <= COL_BLACK;
            cur_bri_q   <= 8'hFF;
            blink_q     <= 8'd0;
            blink_cnt_q <= 8'd0;
            en_q        <= 1'b1;
            red_q       <= 1'b0;
            green_q     <= 1'b0;
            blue_q      <= 1'b0;
        end else begin
            pend_col_q  <= pend_col_d;
            pend_bri_q  <= pend_bri_d;
            pend_vld_q  <= pend_vld_d;
            cur_col_q   <= cur_col_d;
            cur_bri_q   <= cur_bri_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            en_q        <= en_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign RED   = red_q;
    assign GREEN = green_q;
    assign BLUE  = blue_q;
    assign FRAME = wrap_s;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed self-checking bench for rgb_led_pwm, run with a short prescaler so
// each PWM period is 256*(PRESCALE+1) clocks.
module tb_rgb_led_pwm;

    localparam int PRESCALE = 3;
    localparam int CNT_W    = 8;
    localparam int TPT      = PRESCALE + 1;
    localparam int NCYC     = 256 * TPT;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic       RED, GREEN, BLUE, FRAME;

    int errors = 0;
    int checks = 0;

    rgb_led_pwm #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .RED      (RED),
        .GREEN    (GREEN),
        .BLUE     (BLUE),
        .FRAME    (FRAME)
    );

    always #5 CLK = ~CLK;

    // Two-cycle strobe, as the 50 MHz MCU produces.
    task automatic io_write(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    // Leaves the bench at the negedge of the first cycle of the next period.
    task automatic sync_frame(input string tag);
        int k;
        k = 0;
        while (FRAME !== 1'b1 && k < 2 * NCYC) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (FRAME !== 1'b1) begin
            errors++;
            $display("FAIL %s_frame_timeout: FRAME=%b after %0d cycles, required 1", tag, FRAME, k);
        end
        @(negedge CLK);
    endtask

    // Counts high clocks of one full period, starting at its first cycle.
    task automatic measure_period(output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge CLK);
            if (RED === 1'b1)   r++;
            if (GREEN === 1'b1) g++;
            if (BLUE === 1'b1)  b++;
        end
    endtask

    task automatic test_reset();
        int t, hi;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({RED, GREEN, BLUE, FRAME} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000", {RED, GREEN, BLUE, FRAME});
        end
        RESET_N = 1'b1;
        t = 0;
        while (FRAME !== 1'b1 && t < 2 * NCYC) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (t != NCYC - 1) begin
            errors++;
            $display("FAIL first_frame: got %0d cycles, required %0d", t, NCYC - 1);
        end
        for (int p = 0; p < 3; p++) begin
            t = 0; hi = 0;
            do begin
                @(negedge CLK);
                t++;
                if (RED === 1'b1 || GREEN === 1'b1 || BLUE === 1'b1) hi++;
            end while (FRAME !== 1'b1 && t < 2 * NCYC);
            checks++;
            if (t != NCYC) begin
                errors++;
                $display("FAIL frame_spacing[%0d]: got %0d, required %0d", p, t, NCYC);
            end
            checks++;
            if (hi != 0) begin
                errors++;
                $display("FAIL idle_dark[%0d]: got %0d high cycles, required 0", p, hi);
            end
        end
    endtask

    task automatic test_colour_apply();
        int t, hi, r, g, b;
        sync_frame("apply");
        repeat (100) @(negedge CLK);
        io_write(8'h95, 8'h00);
        t = 0; hi = 0;
        while (FRAME !== 1'b1 && t < 2 * NCYC) begin
            @(negedge CLK);
            t++;
            if (RED === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL red_before_frame: got %0d high cycles, required 0", hi);
        end
        @(negedge CLK);
        measure_period(r, g, b);
        checks++;
        if (r != 255 * TPT || g != 0 || b != 0) begin
            errors++;
            $display("FAIL red_duty: got r=%0d g=%0d b=%0d, required %0d 0 0", r, g, b, 255 * TPT);
        end
    endtask

    task automatic test_brightness();
        int r, g, b;
        io_write(8'h9F, 8'h7F);
        io_write(8'h97, 8'h00);
        sync_frame("bright");
        measure_period(r, g, b);
        checks++;
        if (r != 32'h20 * TPT || g != 32'h40 * TPT || b != 32'h7F * TPT) begin
            errors++;
            $display("FAIL liblu_half: got r=%0d g=%0d b=%0d, required %0d %0d %0d",
                     r, g, b, 32'h20 * TPT, 32'h40 * TPT, 32'h7F * TPT);
        end
        io_write(8'h9F, 8'hFF);
        sync_frame("bright_full");
        measure_period(r, g, b);
        checks++;
        if (r != 32'h40 * TPT || g != 32'h80 * TPT || b != 32'hFF * TPT) begin
            errors++;
            $display("FAIL liblu_full: got r=%0d g=%0d b=%0d, required %0d %0d %0d",
                     r, g, b, 32'h40 * TPT, 32'h80 * TPT, 32'hFF * TPT);
        end
    endtask

    task automatic test_wrap_write();
        int t, r, g, b;
        t = 0;
        while (FRAME !== 1'b1 && t < 2 * NCYC) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (FRAME !== 1'b1) begin
            errors++;
            $display("FAIL wrap_wait: FRAME=%b after %0d cycles, required 1", FRAME, t);
        end
        PORT_ID = 8'h9A;
        IO_STRB = 1'b1;
        @(negedge CLK);
        fork
            measure_period(r, g, b);
            begin
                @(negedge CLK);
                IO_STRB = 1'b0;
                PORT_ID = 8'h00;
            end
        join
        checks++;
        if (r != 32'h40 * TPT || g != 32'h80 * TPT || b != 32'hFF * TPT) begin
            errors++;
            $display("FAIL wrap_write_held: got r=%0d g=%0d b=%0d, required %0d %0d %0d",
                     r, g, b, 32'h40 * TPT, 32'h80 * TPT, 32'hFF * TPT);
        end
        measure_period(r, g, b);
        checks++;
        if (r != 255 * TPT || g != 255 * TPT || b != 0) begin
            errors++;
            $display("FAIL wrap_write_yel: got r=%0d g=%0d b=%0d, required %0d %0d 0",
                     r, g, b, 255 * TPT, 255 * TPT);
        end
    endtask

    task automatic test_blink();
        int r, g, b, exp_hi;
        bit on_pat [6];
        on_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        io_write(8'h9D, 8'h00);
        sync_frame("blink_white");
        repeat (50) @(negedge CLK);
        io_write(8'hA0, 8'h02);
        sync_frame("blink_start");
        for (int p = 0; p < 6; p++) begin
            measure_period(r, g, b);
            exp_hi = on_pat[p] ? 255 * TPT : 0;
            checks++;
            if (r != exp_hi || g != exp_hi || b != exp_hi) begin
                errors++;
                $display("FAIL blink_period[%0d]: got r=%0d g=%0d b=%0d, required %0d each",
                         p, r, g, b, exp_hi);
            end
        end
        io_write(8'hA0, 8'h00);
        sync_frame("blink_stop");
        for (int p = 0; p < 2; p++) begin
            measure_period(r, g, b);
            checks++;
            if (r != 255 * TPT || g != 255 * TPT || b != 255 * TPT) begin
                errors++;
                $display("FAIL blink_off_steady[%0d]: got r=%0d g=%0d b=%0d, required %0d each",
                         p, r, g, b, 255 * TPT);
            end
        end
    endtask

    task automatic test_reset_mid_period();
        int t, r, g, b;
        io_write(8'h9B, 8'h00);
        sync_frame("purple");
        repeat (20) @(negedge CLK);
        checks++;
        if ({RED, GREEN, BLUE} !== 3'b101) begin
            errors++;
            $display("FAIL purple_active: got %b, required 101", {RED, GREEN, BLUE});
        end
        RESET_N = 1'b0;
        @(negedge CLK);
        checks++;
        if ({RED, GREEN, BLUE, FRAME} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, required 0000", {RED, GREEN, BLUE, FRAME});
        end
        RESET_N = 1'b1;
        t = 0;
        while (FRAME !== 1'b1 && t < 2 * NCYC) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (t != NCYC - 1) begin
            errors++;
            $display("FAIL post_reset_frame: got %0d cycles, required %0d", t, NCYC - 1);
        end
        @(negedge CLK);
        measure_period(r, g, b);
        checks++;
        if (r != 0 || g != 0 || b != 0) begin
            errors++;
            $display("FAIL post_reset_black: got r=%0d g=%0d b=%0d, required 0 0 0", r, g, b);
        end
        io_write(8'h95, 8'h00);
        sync_frame("post_reset_red");
        measure_period(r, g, b);
        checks++;
        if (r != 255 * TPT || g != 0 || b != 0) begin
            errors++;
            $display("FAIL post_reset_bright: got r=%0d g=%0d b=%0d, required %0d 0 0",
                     r, g, b, 255 * TPT);
        end
    endtask

    initial begin
        test_reset();
        test_colour_apply();
        test_brightness();
        test_wrap_write();
        test_blink();
        test_reset_mid_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
